// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared constants and FSM state type for the AXI memory responder
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] SNOOP_MAKE_INVALID = 4'hD;

  // Snoop addresses are cache-line aligned (64-byte lines).
  localparam int LINE_OFFSET = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_BURST,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_SNOOP
  } state_e;

endpackage

// File: rtl/axi_resp_ram.sv
// rtl/axi_resp_ram.sv - word RAM with byte-strobed synchronous write and combinational read
module axi_resp_ram #(
  parameter int MEM_WORDS  = 4096,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int IDX_W      = $clog2(MEM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      widx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic [IDX_W-1:0]      ridx_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // Contents survive reset on purpose, so there is no reset branch here.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_i[b]) begin
          mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 slave backed by on-chip RAM, one transaction in flight,
// with a MakeInvalid snoop after each completed write burst
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int                    ID_WIDTH     = 13,
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int                    MEM_WORDS    = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    READ_LATENCY = 2,
  parameter int                    SNOOP_EN     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  s_axi_acvalid,
  input  logic                  s_axi_acready,
  output logic [ADDR_WIDTH-1:0] s_axi_acaddr,
  output logic [3:0]            s_axi_acsnoop
);

  localparam int                    IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(MEM_WORDS) << 3;
  localparam logic [ADDR_WIDTH-1:0] BEAT_STEP = ADDR_WIDTH'(8);
  localparam logic [8:0]            LAT_LAST  = 9'(READ_LATENCY - 1);

  state_e                           state_q, state_d;
  logic                             rr_q, rr_d;
  logic [ID_WIDTH-1:0]              id_q, id_d;
  logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
  logic [ADDR_WIDTH-1:LINE_OFFSET]  start_q, start_d;
  logic [7:0]                       len_q, len_d;
  logic [8:0]                       cnt_q, cnt_d;
  logic [1:0]                       bresp_q, bresp_d;
  logic                             decerr_q, decerr_d;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_we;
  logic                  grant_rd, grant_wr, accept;

  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && (offset < SPAN);
  assign idx      = offset[IDX_W+2:3];

  // Round-robin only matters when both requests are present.
  assign grant_rd = s_axi_arvalid && (!s_axi_awvalid || !rr_q);
  assign grant_wr = s_axi_awvalid && (!s_axi_arvalid || rr_q);

  axi_resp_ram #(
    .MEM_WORDS (MEM_WORDS),
    .DATA_WIDTH(DATA_WIDTH),
    .STRB_WIDTH(STRB_WIDTH),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .widx_i (idx),
    .wdata_i(s_axi_wdata),
    .wstrb_i(s_axi_wstrb),
    .ridx_i (idx),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      start_q  <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      bresp_q  <= RESP_OKAY;
      decerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      start_q  <= start_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      bresp_q  <= bresp_d;
      decerr_q <= decerr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    id_d     = id_q;
    addr_d   = addr_q;
    start_d  = start_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    bresp_d  = bresp_q;
    decerr_d = decerr_q;
    ram_we   = 1'b0;
    accept   = 1'b0;

    s_axi_arready = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bid     = '0;
    s_axi_bresp   = '0;
    s_axi_rvalid  = 1'b0;
    s_axi_rid     = '0;
    s_axi_rdata   = '0;
    s_axi_rresp   = '0;
    s_axi_rlast   = 1'b0;
    s_axi_acvalid = 1'b0;
    s_axi_acaddr  = '0;
    s_axi_acsnoop = '0;

    unique case (state_q)
      ST_IDLE: begin
        s_axi_arready = reset && grant_rd;
        s_axi_awready = reset && grant_wr;
        if (grant_rd) begin
          id_d    = s_axi_arid;
          addr_d  = s_axi_araddr;
          start_d = s_axi_araddr[ADDR_WIDTH-1:LINE_OFFSET];
          len_d   = s_axi_arlen;
          cnt_d   = '0;
          rr_d    = ~rr_q;
          state_d = ST_RD_WAIT;
        end else if (grant_wr) begin
          id_d     = s_axi_awid;
          addr_d   = s_axi_awaddr;
          start_d  = s_axi_awaddr[ADDR_WIDTH-1:LINE_OFFSET];
          len_d    = s_axi_awlen;
          cnt_d    = '0;
          decerr_d = 1'b0;
          rr_d     = ~rr_q;
          state_d  = ST_WR_DATA;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          state_d = ST_RD_BURST;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_RD_BURST: begin
        s_axi_rvalid = 1'b1;
        s_axi_rid    = id_q;
        s_axi_rdata  = in_range ? ram_rdata : '0;
        s_axi_rresp  = in_range ? RESP_OKAY : RESP_DECERR;
        s_axi_rlast  = (cnt_q[7:0] == len_q);
        if (s_axi_rready) begin
          if (s_axi_rlast) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d  = cnt_q + 9'd1;
            addr_d = addr_q + BEAT_STEP;
          end
        end
      end
      ST_WR_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          // Beats beyond len+1 still advance the count so the length error is reported.
          accept   = (cnt_q <= {1'b0, len_q});
          ram_we   = accept && in_range;
          decerr_d = decerr_q || (accept && !in_range);
          addr_d   = addr_q + BEAT_STEP;
          cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 9'd1;
          if (s_axi_wlast) begin
            if (cnt_d != {1'b0, len_q} + 9'd1) begin
              bresp_d = RESP_SLVERR;
            end else if (decerr_d) begin
              bresp_d = RESP_DECERR;
            end else begin
              bresp_d = RESP_OKAY;
            end
            state_d = ST_WR_RESP;
          end
        end
      end
      ST_WR_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bid    = id_q;
        s_axi_bresp  = bresp_q;
        if (s_axi_bready) begin
          state_d = (SNOOP_EN != 0) ? ST_SNOOP : ST_IDLE;
        end
      end
      ST_SNOOP: begin
        s_axi_acvalid = 1'b1;
        s_axi_acaddr  = {start_q, {LINE_OFFSET{1'b0}}};
        s_axi_acsnoop = SNOOP_MAKE_INVALID;
        if (s_axi_acready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
